// File: rtl/etc2_seq_pkg.sv
// Shared constants and types for the ETC2 block sequencer and its block buffer.
package etc2_seq_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 2'd0;
  localparam seq_state_t ST_DECODE = 2'd1;
  localparam seq_state_t ST_GEN    = 2'd2;
  localparam seq_state_t ST_OUT    = 2'd3;

  localparam int PIX_PER_BLOCK = 16;
  localparam logic [3:0] LAST_IDX = 4'(PIX_PER_BLOCK - 1);

  // Generator result packing is {a, b, g, r}
  localparam int RGBA_R_LSB = 0;
  localparam int RGBA_G_LSB = 8;
  localparam int RGBA_B_LSB = 16;
  localparam int RGBA_A_LSB = 24;

  typedef struct packed {
    logic        punch;
    logic [63:0] data;
  } etc2_blk_t;

endpackage

// File: rtl/etc2_block_sequencer_skid.sv
// One-entry block buffer (64-bit block + punch-through flag) used for prefetch.
module etc2_blk_skid
  import etc2_seq_pkg::*;
(
  input  logic        sclk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] din_data,
  input  logic        din_punch,
  output logic [63:0] dout_data,
  output logic        dout_punch,
  output logic        valid
);

  etc2_blk_t entry;

  always_ff @(posedge sclk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge sclk) begin
    if (push) begin
      entry.data  <= din_data;
      entry.punch <= din_punch;
    end
  end

  assign dout_data  = entry.data;
  assign dout_punch = entry.punch;

endmodule

// File: rtl/etc2_block_sequencer.sv
// Steps one ETC2 block at a time through mode detect, base-colour decode and 16 pixel
// requests, with a response watchdog. Define ETC2_SEQ_PREFETCH_EN for a one-block prefetch buffer.
//
// state  | meaning
// IDLE   | waiting for a block
// DECODE | mode/base-colour decode launched, waiting for dec_rts
// GEN    | pixel idx requested from generator, waiting for gen_rts
// OUT    | pixel idx presented downstream, waiting for pix_ready
module etc2_block_sequencer
  import etc2_seq_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             blk_valid,
  input  logic [63:0]      blk_data,
  input  logic             blk_punch,
  output logic             blk_ready,
  output logic [63:0]      dec_block,
  output logic             dec_flags,
  output logic             dec_start,
  input  logic             dec_rts,
  output logic             gen_rtr,
  output logic [3:0]       gen_pix_idx,
  input  logic             gen_rts,
  input  logic [31:0]      gen_rgba,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [31:0]      pix_rgba,
  output logic [3:0]       pix_idx,
  output logic             pix_last,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);

  localparam int WD_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WAIT_MAX - 1);

  seq_state_t      state;
  logic [3:0]      idx;
  logic [WD_W-1:0] wd_cnt;

  logic        blk_hs;
  logic        nxt_avail;
  logic [63:0] nxt_data;
  logic        nxt_punch;
  logic        last_hs;
  logic        consume;
  logic        wd_expired;

  assign last_hs    = (state == ST_OUT) && pix_ready && (idx == LAST_IDX);
  assign consume    = nxt_avail && ((state == ST_IDLE) || last_hs);
  assign wd_expired = (wd_cnt == WD_LIM);
  assign busy       = (state != ST_IDLE);
  assign gen_pix_idx = idx;

`ifdef ETC2_SEQ_PREFETCH_EN
  logic        buf_valid;
  logic [63:0] buf_data;
  logic        buf_punch;
  logic        buf_push;
  logic        buf_pop;

  assign blk_ready = !buf_valid && !rst;
  assign blk_hs    = blk_valid && blk_ready;
  assign nxt_avail = buf_valid || blk_hs;
  assign nxt_data  = buf_valid ? buf_data : blk_data;
  assign nxt_punch = buf_valid ? buf_punch : blk_punch;
  // An incoming block consumed in its acceptance cycle bypasses the buffer
  assign buf_push  = blk_hs && !(consume && !buf_valid);
  assign buf_pop   = consume && buf_valid;

  etc2_blk_skid u_skid (
    .sclk       (sclk),
    .rst        (rst),
    .push       (buf_push),
    .pop        (buf_pop),
    .din_data   (blk_data),
    .din_punch  (blk_punch),
    .dout_data  (buf_data),
    .dout_punch (buf_punch),
    .valid      (buf_valid)
  );
`else
  assign blk_ready = (state == ST_IDLE) && !rst;
  assign blk_hs    = blk_valid && blk_ready;
  assign nxt_avail = blk_hs;
  assign nxt_data  = blk_data;
  assign nxt_punch = blk_punch;
`endif

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 4'd0;
      wd_cnt    <= '0;
      dec_block <= 64'd0;
      dec_flags <= 1'b0;
      dec_start <= 1'b0;
      gen_rtr   <= 1'b0;
      pix_valid <= 1'b0;
      pix_rgba  <= 32'd0;
      pix_idx   <= 4'd0;
      pix_last  <= 1'b0;
      err       <= 1'b0;
      blk_count <= '0;
    end else begin
      dec_start <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (consume) begin
            dec_block <= nxt_data;
            dec_flags <= nxt_punch;
            dec_start <= 1'b1;
            idx       <= 4'd0;
            wd_cnt    <= '0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_rts) begin
            gen_rtr <= 1'b1;
            wd_cnt  <= '0;
            state   <= ST_GEN;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_GEN: begin
          if (gen_rts) begin
            pix_rgba  <= gen_rgba;
            pix_idx   <= idx;
            pix_last  <= (idx == LAST_IDX);
            pix_valid <= 1'b1;
            gen_rtr   <= 1'b0;
            state     <= ST_OUT;
          end else if (wd_expired) begin
            err     <= 1'b1;
            gen_rtr <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (idx == LAST_IDX) begin
              blk_count <= blk_count + CNT_W'(1);
              if (consume) begin
                dec_block <= nxt_data;
                dec_flags <= nxt_punch;
                dec_start <= 1'b1;
                idx       <= 4'd0;
                wd_cnt    <= '0;
                state     <= ST_DECODE;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx     <= idx + 4'd1;
              gen_rtr <= 1'b1;
              wd_cnt  <= '0;
              state   <= ST_GEN;
            end
          end
        end
      endcase
    end
  end

endmodule
